// File: rtl/bean_pkg.sv
`default_nettype none
// ============================================================================
// bean_pkg : grid constants, LFSR constants and seeder state encoding
// Rev 1.0
// ============================================================================
package bean_pkg;

  localparam int GRID_W    = 64;
  localparam int GRID_H    = 48;
  localparam int CELL_SIZE = 10;
  localparam int ADDR_W    = 12;

  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GEN    = 3'd2,
    ST_READ   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_WRITE  = 3'd5,
    ST_FINISH = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// lfsr16 : 16-bit right-shifting Galois LFSR with synchronous load and enable
// Rev 1.0
// ============================================================================
module lfsr16 #(
  parameter logic [15:0] TAPS = bean_pkg::LFSR_TAPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        enable,
  input  logic [15:0] load_value,
  output logic [15:0] state,
  output logic [15:0] next_state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    next_state = {1'b0, state_q[15:1]} ^ (state_q[0] ? TAPS : 16'h0000);
    state_d    = state_q;
    if (load) begin
      state_d = load_value;
    end else if (enable) begin
      state_d = next_state;
    end
  end

  // Never reset to zero: an all-zero state would lock the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= bean_pkg::LFSR_ZERO_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/bean_seeder.sv
`default_nettype none
// ============================================================================
// bean_seeder : clears the bean RAM, then writes BEAN_COUNT distinct legal beans
// Rev 1.0
// ============================================================================
module bean_seeder #(
  parameter int          GRID_W        = bean_pkg::GRID_W,
  parameter int          GRID_H        = bean_pkg::GRID_H,
  parameter int          BEAN_COUNT    = 5,
  parameter int          PLAYER_CELL_X = 1,
  parameter int          PLAYER_CELL_Y = 1,
  parameter logic [15:0] MAX_TRIES     = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] seed,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic        ram_wdata,
  input  logic        ram_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  beans_placed
);
  import bean_pkg::*;

  localparam int X_W = $clog2(GRID_W);
  localparam int Y_W = ADDR_W - X_W;

  localparam logic [X_W-1:0]    X_LAST     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]    PLAYER_X   = X_W'(PLAYER_CELL_X);
  localparam logic [Y_W-1:0]    PLAYER_Y   = Y_W'(PLAYER_CELL_Y);
  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [7:0]        BEANS_END  = 8'(BEAN_COUNT);

  state_t      state_q, state_d;
  logic [11:0] ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic        ram_wdata_q, ram_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [7:0]  beans_q, beans_d;
  logic [15:0] tries_q, tries_d;

  logic        lfsr_load, lfsr_en;
  logic [15:0] lfsr_seed, lfsr_state, lfsr_next;
  logic        unused_lfsr_bits;

  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;
  logic           cand_legal;
  logic [16:0]    tries_inc;
  logic           try_limit;
  logic           reject;

  assign lfsr_seed = (seed == 16'h0000) ? LFSR_ZERO_SEED : seed;

  lfsr16 #(
    .TAPS(LFSR_TAPS)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (lfsr_load),
    .enable    (lfsr_en),
    .load_value(lfsr_seed),
    .state     (lfsr_state),
    .next_state(lfsr_next)
  );

  assign unused_lfsr_bits = ^{lfsr_state, lfsr_next[15:ADDR_W]};

  // Candidate comes from the value the LFSR advances to in this GEN cycle.
  assign cand_x     = lfsr_next[X_W-1:0];
  assign cand_y     = lfsr_next[X_W +: Y_W];
  assign cand_legal = (cand_y < Y_LAST) && (cand_y != '0) &&
                      (cand_x != '0) && (cand_x != X_LAST) &&
                      !((cand_x == PLAYER_X) && (cand_y == PLAYER_Y));

  assign tries_inc = {1'b0, tries_q} + 17'd1;
  assign try_limit = (tries_inc >= {1'b0, MAX_TRIES});

  always_comb begin
    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    beans_d     = beans_q;
    tries_d     = tries_q;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;
    reject      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_CLEAR;
          ram_addr_d = '0;
          ram_we_d   = 1'b1;
          busy_d     = 1'b1;
          error_d    = 1'b0;
          beans_d    = '0;
          tries_d    = '0;
          lfsr_load  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (ram_addr_q == CLEAR_LAST) begin
          state_d = ST_GEN;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
          ram_we_d   = 1'b1;
        end
      end
      ST_GEN: begin
        lfsr_en = 1'b1;
        if (cand_legal) begin
          ram_addr_d = {cand_y, cand_x};
          state_d    = ST_READ;
        end else begin
          reject = 1'b1;
        end
      end
      ST_READ: state_d = ST_CHECK;
      ST_CHECK: begin
        if (ram_rdata) begin
          reject = 1'b1;
        end else begin
          ram_we_d    = 1'b1;
          ram_wdata_d = 1'b1;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        beans_d = beans_q + 8'd1;
        if (beans_q + 8'd1 == BEANS_END) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_FINISH;
        end else begin
          state_d = ST_GEN;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Out-of-range candidates and duplicates share one try budget.
    if (reject) begin
      if (try_limit) begin
        tries_d = MAX_TRIES;
        error_d = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_FINISH;
      end else begin
        tries_d = tries_inc[15:0];
        state_d = ST_GEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      beans_q     <= '0;
      tries_q     <= '0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      beans_q     <= beans_d;
      tries_q     <= tries_d;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_we       = ram_we_q;
  assign ram_wdata    = ram_wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign beans_placed = beans_q;

endmodule
`default_nettype wire

// File: tb/tb_bean_seeder.sv
`default_nettype none
// ============================================================================
// tb_bean_seeder : directed self-checking bench for bean_seeder
// Rev 1.0
// ============================================================================
module tb_bean_seeder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed  = 16'h0000;
  logic [11:0] ram_addr;
  logic        ram_we, ram_wdata, busy, done, error;
  logic        ram_rdata = 1'b0;
  logic [7:0]  beans_placed;

  logic        t_start = 1'b0;
  logic [15:0] t_seed  = 16'h1234;
  logic [11:0] t_ram_addr;
  logic        t_ram_we, t_ram_wdata, t_busy, t_done, t_error;
  logic [7:0]  t_beans;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bean_seeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .done(done), .error(error),
    .beans_placed(beans_placed)
  );

  // Second instance sees a RAM that always reads back "occupied".
  bean_seeder #(.MAX_TRIES(16'd20)) dut_t (
    .clk(clk), .rst_n(rst_n), .start(t_start), .seed(t_seed),
    .ram_addr(t_ram_addr), .ram_we(t_ram_we), .ram_wdata(t_ram_wdata),
    .ram_rdata(1'b1), .busy(t_busy), .done(t_done), .error(t_error),
    .beans_placed(t_beans)
  );

  // Behavioural 4096x1 RAM, one-cycle read; optional one-shot forced duplicate.
  logic mem [0:4095];
  logic dup_req  = 1'b0;
  logic dup_done = 1'b0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (dup_req && !dup_done && busy && !ram_we && ram_addr != 12'd3071) begin
      ram_rdata <= 1'b1;
      dup_done  <= 1'b1;
    end else begin
      ram_rdata <= mem[ram_addr];
    end
  end

  int          zero_writes, one_writes, order_err, done_cnt;
  logic [11:0] bean_addrs[$];
  logic [11:0] exp_q[$];
  logic [11:0] z_q[$];

  always @(negedge clk) begin
    if (ram_we && !ram_wdata) begin
      if (one_writes != 0 || ram_addr != 12'(zero_writes)) order_err++;
      zero_writes++;
    end
    if (ram_we && ram_wdata) begin
      if (zero_writes != 3072) order_err++;
      one_writes++;
      bean_addrs.push_back(ram_addr);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference bean sequence for a default-parameter round.
  task automatic model_beans(input logic [15:0] s_in, input bit skip_first);
    logic [15:0] s;
    logic [5:0]  x, y;
    bit          skip, seen;
    exp_q.delete();
    s    = (s_in == 16'h0) ? 16'hACE1 : s_in;
    skip = skip_first;
    for (int n = 0; n < 100000 && exp_q.size() < 5; n++) begin
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
      x = s[5:0];
      y = s[11:6];
      if (y >= 6'd47 || y == 6'd0 || x == 6'd0 || x == 6'd63 || (x == 6'd1 && y == 6'd1))
        continue;
      if (skip) begin
        skip = 1'b0;
        continue;
      end
      seen = 1'b0;
      foreach (exp_q[k]) if (exp_q[k] == {y, x}) seen = 1'b1;
      if (!seen) exp_q.push_back({y, x});
    end
  endtask

  task automatic start_round(input string tag, input logic [15:0] s);
    #1;
    zero_writes = 0; one_writes = 0; order_err = 0; done_cnt = 0;
    bean_addrs.delete();
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_accept_busy"}, busy, 1);
    chk({tag, "_accept_we"}, ram_we, 1);
    chk({tag, "_accept_addr"}, ram_addr, 0);
    chk({tag, "_accept_error"}, error, 0);
  endtask

  task automatic wait_addr(input logic [11:0] a);
    int n = 0;
    while (!(ram_we && ram_addr == a) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_clear_addr", ram_addr, a);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic check_round(input string tag);
    int bad = 0;
    repeat (3) @(negedge clk);
    chk({tag, "_zero_writes"}, zero_writes, 3072);
    chk({tag, "_one_writes"}, one_writes, 5);
    chk({tag, "_order"}, order_err, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_beans_placed"}, beans_placed, 5);
    chk({tag, "_error"}, error, 0);
    for (int i = 0; i < 5; i++) begin
      logic [11:0] a;
      a = (i < bean_addrs.size()) ? bean_addrs[i] : 12'hFFF;
      chk($sformatf("%s_bean%0d", tag, i), a, exp_q[i]);
      if (a[5:0] == 0 || a[5:0] == 63 || a[11:6] == 0 || a[11:6] >= 47 || a == 12'h041) bad++;
      for (int j = 0; j < i; j++) if (bean_addrs[j] == a) bad++;
    end
    chk({tag, "_legal_distinct"}, bad, 0);
  endtask

  initial begin
    int busy_hi = 0;
    int n;

    @(negedge clk);
    chk("rst_addr", ram_addr, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_beans", beans_placed, 0);
    rst_n = 1'b1;
    repeat (10000) begin
      @(negedge clk);
      if (busy) busy_hi++;
    end
    chk("idle_busy_never", busy_hi, 0);

    // Seed 0x1234 with an ignored start pulse in the middle of CLEAR.
    model_beans(16'h1234, 1'b0);
    start_round("s1234", 16'h1234);
    wait_addr(12'd500);
    seed  = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("s1234");
    check_round("s1234");

    // Zero seed must behave exactly like 0xACE1.
    model_beans(16'hACE1, 1'b0);
    start_round("s0", 16'h0000);
    wait_done("s0");
    check_round("s0");
    z_q = bean_addrs;
    start_round("sace1", 16'hACE1);
    wait_done("sace1");
    check_round("sace1");
    for (int i = 0; i < 5; i++)
      chk($sformatf("zero_vs_ace1_%0d", i), bean_addrs[i], (i < z_q.size()) ? z_q[i] : 12'hFFF);

    // First CHECK reads back "occupied": that candidate is skipped.
    model_beans(16'h1234, 1'b1);
    dup_req = 1'b1;
    start_round("dup", 16'h1234);
    wait_done("dup");
    check_round("dup");
    chk("dup_forced", dup_done, 1);
    dup_req = 1'b0;

    // Reset in the middle of CLEAR, then a clean restart.
    start_round("rstmid", 16'h1234);
    wait_addr(12'd1000);
    rst_n = 1'b0;
    #1;
    chk("rstmid_we", ram_we, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_addr", ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_idle_busy", busy, 0);
    model_beans(16'h1234, 1'b0);
    start_round("restart", 16'h1234);
    wait_done("restart");
    check_round("restart");

    // Try limit on the instance whose RAM always reads 1.
    @(negedge clk);
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    chk("tl_busy", t_busy, 1);
    n = 0;
    while (t_done !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("tl_done", t_done, 1);
    chk("tl_error", t_error, 1);
    chk("tl_beans", t_beans, 0);
    chk("tl_busy_at_done", t_busy, 0);
    @(negedge clk);
    chk("tl_error_sticky", t_error, 1);
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    chk("tl_error_cleared", t_error, 0);
    n = 0;
    while (t_done !== 1'b1 && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("tl_error_again", t_error, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
